// File: rtl/vc_mem_req_arbiter_2port.sv
// Two-requester round-robin arbiter in front of one val/rdy memory port.
// An ID FIFO tracks in-flight requests so responses are steered back in issue order.
module vc_mem_req_arbiter_2port #(
  parameter int p_addr_sz      = 8,
  parameter int p_data_sz      = 32,
  parameter int p_num_inflight = 2,
  localparam int LEN = $clog2(p_data_sz/8),
  localparam int REQ  = 1 + p_addr_sz + LEN + p_data_sz,
  localparam int RESP = 1 + LEN + p_data_sz
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            memreq0_val,
  output logic            memreq0_rdy,
  input  logic [REQ-1:0]  memreq0_msg,
  output logic            memresp0_val,
  input  logic            memresp0_rdy,
  output logic [RESP-1:0] memresp0_msg,

  input  logic            memreq1_val,
  output logic            memreq1_rdy,
  input  logic [REQ-1:0]  memreq1_msg,
  output logic            memresp1_val,
  input  logic            memresp1_rdy,
  output logic [RESP-1:0] memresp1_msg,

  output logic            mem_memreq_val,
  input  logic            mem_memreq_rdy,
  output logic [REQ-1:0]  mem_memreq_msg,
  input  logic            mem_memresp_val,
  output logic            mem_memresp_rdy,
  input  logic [RESP-1:0] mem_memresp_msg
);

  localparam int PTR_W = (p_num_inflight > 1) ? $clog2(p_num_inflight) : 1;
  localparam int CNT_W = $clog2(p_num_inflight + 1);

  logic [p_num_inflight-1:0] id_q;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      prio;

  logic empty, full, head, pop, push, can_issue, grant0, grant1;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_num_inflight - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(p_num_inflight));
  assign head  = id_q[rd_ptr];

  // Response side: owner at the FIFO head gets the response; empty FIFO never stalls memory.
  assign mem_memresp_rdy = empty ? 1'b1 : (head ? memresp1_rdy : memresp0_rdy);
  assign pop             = mem_memresp_val & mem_memresp_rdy & !empty;
  assign memresp0_val    = !reset & mem_memresp_val & !empty & !head;
  assign memresp1_val    = !reset & mem_memresp_val & !empty &  head;
  assign memresp0_msg    = mem_memresp_msg;
  assign memresp1_msg    = mem_memresp_msg;

  // Request side: a slot freed by this cycle's pop may be reused immediately.
  assign can_issue      = !full | pop;
  assign grant1         = memreq1_val & (!memreq0_val | prio);
  assign grant0         = memreq0_val & !grant1;
  assign mem_memreq_val = !reset & (memreq0_val | memreq1_val) & can_issue;
  assign mem_memreq_msg = grant1 ? memreq1_msg : memreq0_msg;
  assign memreq0_rdy    = grant0 & can_issue & mem_memreq_rdy;
  assign memreq1_rdy    = grant1 & can_issue & mem_memreq_rdy;
  assign push           = mem_memreq_val & mem_memreq_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      prio   <= 1'b0;
    end else begin
      if (push) begin
        id_q[wr_ptr] <= grant1;
        wr_ptr       <= nxt(wr_ptr);
        prio         <= !grant1;
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_memresp_val && empty));
      assert (!$isunknown({memreq0_val, memreq1_val, memresp0_rdy, memresp1_rdy,
                           mem_memreq_rdy, mem_memresp_val}));
    end
  end

endmodule

// File: tb/tb_vc_mem_req_arbiter_2port.sv
// Directed bench: arbiter plus a behavioural one-cycle-latency memory and requester queues.
module tb_vc_mem_req_arbiter_2port;
  localparam int REQ  = 43;
  localparam int RESP = 35;

  logic clk = 1'b0;
  logic reset;
  logic memreq0_val, memreq0_rdy, memresp0_val, memresp0_rdy;
  logic memreq1_val, memreq1_rdy, memresp1_val, memresp1_rdy;
  logic [REQ-1:0]  memreq0_msg, memreq1_msg, mem_memreq_msg;
  logic [RESP-1:0] memresp0_msg, memresp1_msg, mem_memresp_msg;
  logic mem_memreq_val, mem_memreq_rdy, mem_memresp_val, mem_memresp_rdy;

  always #5 clk = ~clk;

  vc_mem_req_arbiter_2port dut (
    .clk(clk), .reset(reset),
    .memreq0_val(memreq0_val), .memreq0_rdy(memreq0_rdy), .memreq0_msg(memreq0_msg),
    .memresp0_val(memresp0_val), .memresp0_rdy(memresp0_rdy), .memresp0_msg(memresp0_msg),
    .memreq1_val(memreq1_val), .memreq1_rdy(memreq1_rdy), .memreq1_msg(memreq1_msg),
    .memresp1_val(memresp1_val), .memresp1_rdy(memresp1_rdy), .memresp1_msg(memresp1_msg),
    .mem_memreq_val(mem_memreq_val), .mem_memreq_rdy(mem_memreq_rdy),
    .mem_memreq_msg(mem_memreq_msg),
    .mem_memresp_val(mem_memresp_val), .mem_memresp_rdy(mem_memresp_rdy),
    .mem_memresp_msg(mem_memresp_msg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]     mem_arr [0:255];
  logic [REQ-1:0]  req_q0[$], req_q1[$];
  logic [RESP-1:0] mem_q[$], log0[$], log1[$];
  int              grant_log[$];
  logic            resp_en;
  logic [1:0]      rrdy;

  function automatic logic [REQ-1:0] mk_req(input logic wr, input logic [7:0] a,
                                            input logic [31:0] d);
    return {wr, a, 2'd0, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    memreq0_val     = (req_q0.size() > 0);
    memreq0_msg     = memreq0_val ? req_q0[0] : '0;
    memreq1_val     = (req_q1.size() > 0);
    memreq1_msg     = memreq1_val ? req_q1[0] : '0;
    mem_memresp_val = resp_en && (mem_q.size() > 0);
    mem_memresp_msg = (mem_q.size() > 0) ? mem_q[0] : '0;
    memresp0_rdy    = rrdy[0];
    memresp1_rdy    = rrdy[1];
    mem_memreq_rdy  = 1'b1;
  endtask

  // Record this cycle's handshakes, then advance to the next negedge.
  task automatic commit();
    logic [REQ-1:0] m;
    if (!reset) begin
      if (memresp0_val && memresp0_rdy) log0.push_back(memresp0_msg);
      if (memresp1_val && memresp1_rdy) log1.push_back(memresp1_msg);
      if (mem_memresp_val && mem_memresp_rdy) void'(mem_q.pop_front());
      if (mem_memreq_val && mem_memreq_rdy) begin
        m = mem_memreq_msg;
        grant_log.push_back(memreq1_rdy ? 1 : 0);
        if (m[42]) begin
          mem_arr[m[41:34]] = m[31:0];
          mem_q.push_back({1'b1, 2'd0, 32'd0});
        end else
          mem_q.push_back({1'b0, 2'd0, mem_arr[m[41:34]]});
      end
      if (memreq0_val && memreq0_rdy && req_q0.size() > 0) void'(req_q0.pop_front());
      if (memreq1_val && memreq1_rdy && req_q1.size() > 0) void'(req_q1.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      drive(); #1; commit();
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((req_q0.size() > 0 || req_q1.size() > 0 || mem_q.size() > 0) && k < 300) begin
      drive(); #1; commit();
      k++;
    end
    chk("drain_bound", {63'd0, k < 300}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(); #1; commit();
    reset = 1'b0;
    mem_q.delete(); req_q0.delete(); req_q1.delete();
    log0.delete(); log1.delete(); grant_log.delete();
  endtask

  typedef struct {
    logic v0, v1, mrdy, rr0;
    logic e_mval, e_r0, e_r1, e_sel, e_mresp_rdy;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [REQ-1:0] msg0, msg1;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | i;
    reset = 1'b1; resp_en = 1'b0; rrdy = 2'b11;
    drive();
    @(negedge clk);
    do_reset();

    // Reset-state combinational vectors, memory responses held off.
    tbl[0] = '{0,0,1,0, 0,0,0,0,1};
    tbl[1] = '{1,1,0,1, 1,0,0,0,1};
    tbl[2] = '{0,1,0,0, 1,0,0,1,1};
    tbl[3] = '{1,1,1,0, 1,1,0,0,1};
    tbl[4] = '{1,1,0,1, 1,0,0,1,1};
    tbl[5] = '{1,0,1,0, 1,1,0,0,0};
    tbl[6] = '{1,1,1,0, 0,0,0,1,0};
    tbl[7] = '{0,0,0,1, 0,0,0,0,1};
    msg0 = mk_req(1'b0, 8'hA0, 32'h0);
    msg1 = mk_req(1'b1, 8'hB1, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      drive();
      memreq0_val = tbl[i].v0;   memreq0_msg = msg0;
      memreq1_val = tbl[i].v1;   memreq1_msg = msg1;
      mem_memreq_rdy = tbl[i].mrdy;
      memresp0_rdy = tbl[i].rr0; memresp1_rdy = 1'b1;
      #1;
      chk($sformatf("v%0d_mreq_val", i), {63'd0, mem_memreq_val}, {63'd0, tbl[i].e_mval});
      chk($sformatf("v%0d_req0_rdy", i), {63'd0, memreq0_rdy}, {63'd0, tbl[i].e_r0});
      chk($sformatf("v%0d_req1_rdy", i), {63'd0, memreq1_rdy}, {63'd0, tbl[i].e_r1});
      chk($sformatf("v%0d_mreq_msg", i), {21'd0, mem_memreq_msg},
          {21'd0, tbl[i].e_sel ? msg1 : msg0});
      chk($sformatf("v%0d_mresp_rdy", i), {63'd0, mem_memresp_rdy},
          {63'd0, tbl[i].e_mresp_rdy});
      chk($sformatf("v%0d_resp_vals", i), {62'd0, memresp1_val, memresp0_val}, 64'd0);
      commit();
    end
    resp_en = 1'b1;
    drain();
    chk("tbl_drain_n0", log0.size(), 2);
    chk("tbl_drain_n1", log1.size(), 0);

    // Port 0 only: four reads.
    do_reset();
    for (int i = 0; i < 4; i++) req_q0.push_back(mk_req(1'b0, 8'(4*i), 32'd0));
    drain();
    chk("p0only_n0", log0.size(), 4);
    chk("p0only_n1", log1.size(), 0);
    for (int i = 0; i < 4 && i < log0.size(); i++)
      chk($sformatf("p0only_data%0d", i), {32'd0, log0[i][31:0]}, {32'd0, 32'hA500_0000 | 32'(4*i)});

    // Both ports busy: strict alternation starting with port 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_q0.push_back(mk_req(1'b0, 8'(8'h20 + 4*i), 32'd0));
      req_q1.push_back(mk_req(1'b0, 8'(8'h80 + 4*i), 32'd0));
    end
    drain();
    chk("rr_ngrant", grant_log.size(), 16);
    for (int i = 0; i < 16 && i < grant_log.size(); i++)
      chk($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
    chk("rr_n0", log0.size(), 8);
    chk("rr_n1", log1.size(), 8);
    for (int i = 0; i < 8 && i < log1.size(); i++)
      chk($sformatf("rr_p1_data%0d", i), {32'd0, log1[i][31:0]},
          {32'd0, 32'hA500_0080 + 32'(4*i)});

    // Write from port 1, read back from port 0.
    do_reset();
    req_q1.push_back(mk_req(1'b1, 8'h10, 32'hDEAD_BEEF));
    drain();
    req_q0.push_back(mk_req(1'b0, 8'h10, 32'd0));
    drain();
    chk("wr_n1", log1.size(), 1);
    chk("wr_n0", log0.size(), 1);
    if (log1.size() > 0) chk("wr_type", {63'd0, log1[0][34]}, 64'd1);
    if (log0.size() > 0) chk("rd_data", {32'd0, log0[0][31:0]}, 64'h0000_0000_DEAD_BEEF);

    // Port 0 stalls its response; FIFO fills and both requesters are blocked.
    do_reset();
    rrdy = 2'b10;
    for (int i = 0; i < 3; i++) req_q0.push_back(mk_req(1'b0, 8'(8'h50 + 4*i), 32'd0));
    for (int i = 0; i < 2; i++) req_q1.push_back(mk_req(1'b0, 8'(8'h60 + 4*i), 32'd0));
    cyc(5);
    drive(); #1;
    chk("stall_mresp_rdy", {63'd0, mem_memresp_rdy}, 64'd0);
    chk("stall_req_rdys", {62'd0, memreq1_rdy, memreq0_rdy}, 64'd0);
    chk("stall_mreq_val", {63'd0, mem_memreq_val}, 64'd0);
    chk("stall_count", {62'd0, dut.count}, 64'd2);
    chk("stall_no_bypass", log1.size(), 0);
    // Release: pop and accept in the same cycle while full.
    rrdy = 2'b11;
    drive(); #1;
    chk("fullpop_resp0_val", {63'd0, memresp0_val}, 64'd1);
    chk("fullpop_req0_rdy", {63'd0, memreq0_rdy}, 64'd1);
    chk("fullpop_mreq_val", {63'd0, mem_memreq_val}, 64'd1);
    commit();
    chk("fullpop_count", {62'd0, dut.count}, 64'd2);
    drain();
    chk("stall_n0", log0.size(), 3);
    chk("stall_n1", log1.size(), 2);
    for (int i = 0; i < 3 && i < log0.size(); i++)
      chk($sformatf("stall_p0_data%0d", i), {32'd0, log0[i][31:0]},
          {32'd0, 32'hA500_0050 + 32'(4*i)});
    for (int i = 0; i < 2 && i < log1.size(); i++)
      chk($sformatf("stall_p1_data%0d", i), {32'd0, log1[i][31:0]},
          {32'd0, 32'hA500_0060 + 32'(4*i)});

    // Reset with two requests in flight and priority pointing at port 1.
    do_reset();
    resp_en = 1'b0;
    req_q0.push_back(mk_req(1'b0, 8'h70, 32'd0));
    req_q0.push_back(mk_req(1'b0, 8'h74, 32'd0));
    cyc(2);
    chk("mid_issued", grant_log.size(), 2);
    req_q0.push_back(mk_req(1'b0, 8'h78, 32'd0));
    req_q1.push_back(mk_req(1'b0, 8'h7C, 32'd0));
    resp_en = 1'b1;
    rrdy = 2'b00;
    reset = 1'b1;
    drive(); #1;
    chk("rst_vals", {61'd0, mem_memreq_val, memresp1_val, memresp0_val}, 64'd0);
    commit();
    reset = 1'b0;
    mem_q.delete();
    drive(); #1;
    chk("rst_empty", {63'd0, mem_memresp_rdy}, 64'd1);
    chk("rst_grant", {62'd0, memreq1_rdy, memreq0_rdy}, 64'd1);
    chk("rst_msg", {21'd0, mem_memreq_msg}, {21'd0, mk_req(1'b0, 8'h78, 32'd0)});
    commit();
    rrdy = 2'b11;
    drain();
    chk("rst_n0", log0.size(), 1);
    chk("rst_n1", log1.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
